// File: rtl/arbitro_mux_rr.sv
// arbitro_mux_rr: round-robin arbiter driving a shared
// 4:1 registered mux with time-limited grants.
module arbitro_mux_rr #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic [3:0] iReq,
  input  logic [3:0] iData,
  output logic [3:0] oGrant,
  output logic [1:0] oSelector,
  output logic       oSalida,
  output logic       oValid,
  output logic       oBusy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] CntLoad = 4'(HOLD_CYCLES - 1);

  state_t     state;
  state_t     nState;
  logic [1:0] rPtr;
  logic [1:0] nPtr;
  logic [3:0] counter;
  logic [3:0] nCounter;
  logic [3:0] nGrant;
  logic [1:0] nSelector;
  logic [1:0] win;
  logic [1:0] idx;

  assign oBusy = (state == GRANT);

  // First requester found searching from rPtr upward (mod 4)
  always_comb begin
    win = rPtr;
    idx = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = rPtr + 2'(k);
      if (iReq[idx]) win = idx;
    end
  end

  // Next-state: arbitrate in IDLE, count down or release in GRANT
  always_comb begin
    nState    = state;
    nPtr      = rPtr;
    nCounter  = counter;
    nGrant    = oGrant;
    nSelector = oSelector;
    unique case (state)
      IDLE: begin
        nGrant = '0;
        if (|iReq) begin
          nState    = GRANT;
          nGrant    = 4'b0001 << win;
          nSelector = win;
          nPtr      = win + 2'd1;
          nCounter  = CntLoad;
        end
      end
      GRANT: begin
        if (!iReq[oSelector] || counter == '0) begin
          nState = IDLE;
          nGrant = '0;
        end else begin
          nCounter = counter - 4'd1;
        end
      end
      default: begin
        nState = IDLE;
        nGrant = '0;
      end
    endcase
  end

  // Control state registers
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state     <= IDLE;
      rPtr      <= '0;
      counter   <= '0;
      oGrant    <= '0;
      oSelector <= '0;
    end else begin
      state     <= nState;
      rPtr      <= nPtr;
      counter   <= nCounter;
      oGrant    <= nGrant;
      oSelector <= nSelector;
    end
  end

  // Registered mux output, valid one cycle behind the grant
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oSalida <= 1'b0;
      oValid  <= 1'b0;
    end else begin
      oSalida <= iData[oSelector];
      oValid  <= (state == GRANT);
    end
  end

endmodule

// File: tb/tb_arbitro_mux_rr.sv
// tb_arbitro_mux_rr: directed self-checking bench
// for the round-robin mux arbiter.
module tb_arbitro_mux_rr;

  logic       iClk;
  logic       iRst_n;
  logic [3:0] iReq;
  logic [3:0] iData;
  logic [3:0] oGrant;
  logic [1:0] oSelector;
  logic       oSalida;
  logic       oValid;
  logic       oBusy;

  int checks = 0;
  int errors = 0;

  arbitro_mux_rr #(.HOLD_CYCLES(4)) dut (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iReq      (iReq),
    .iData     (iData),
    .oGrant    (oGrant),
    .oSelector (oSelector),
    .oSalida   (oSalida),
    .oValid    (oValid),
    .oBusy     (oBusy)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic chk(input string tag,
                     input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  initial begin
    logic [1:0] w;
    iRst_n = 1'b0;
    iReq   = 4'b1111;
    iData  = 4'b0000;
    #2;
    chk("rst_grant", oGrant, 4'b0000);
    chk("rst_sel", {2'b00, oSelector}, 4'd0);
    chk("rst_sal", {3'b000, oSalida}, 4'd0);
    chk("rst_valid", {3'b000, oValid}, 4'd0);
    chk("rst_busy", {3'b000, oBusy}, 4'd0);
    iReq = 4'b0000;
    #1 iRst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("idle_grant", oGrant, 4'b0000);
      chk("idle_busy", {3'b000, oBusy}, 4'd0);
    end

    // single persistent requester 2
    iReq = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("single_grant", oGrant,
          (c % 5 < 4) ? 4'b0100 : 4'b0000);
      chk("single_sel", {2'b00, oSelector}, 4'd2);
      chk("single_valid", {3'b000, oValid},
          (c != 0 && (c - 1) % 5 < 4) ? 4'd1 : 4'd0);
    end
    iReq = 4'b0000;

    // rotation from reset with all requesting
    iRst_n = 1'b0;
    #1 iRst_n = 1'b1;
    iReq = 4'b1111;
    for (int c = 0; c < 25; c++) begin
      step();
      w = 2'((c / 5) % 4);
      chk("rot_grant", oGrant,
          (c % 5 < 4) ? (4'b0001 << w) : 4'b0000);
      chk("rot_sel", {2'b00, oSelector}, {2'b00, w});
      chk("rot_busy", {3'b000, oBusy},
          (c % 5 < 4) ? 4'd1 : 4'd0);
    end
    iReq = 4'b0000;

    // early release by requester 1
    step();
    iReq = 4'b0010;
    step();
    chk("early_g0", oGrant, 4'b0010);
    chk("early_v0", {3'b000, oValid}, 4'd0);
    step();
    chk("early_g1", oGrant, 4'b0010);
    chk("early_v1", {3'b000, oValid}, 4'd1);
    iReq = 4'b0000;
    step();
    chk("early_g2", oGrant, 4'b0000);
    chk("early_b2", {3'b000, oBusy}, 4'd0);
    chk("early_v2", {3'b000, oValid}, 4'd1);
    step();
    chk("early_v3", {3'b000, oValid}, 4'd0);

    // data path through requester 3
    iReq  = 4'b1000;
    iData = 4'b0000;
    step();
    chk("data_grant", oGrant, 4'b1000);
    chk("data_sel", {2'b00, oSelector}, 4'd3);
    iData = 4'b1000;
    step();
    chk("data_s0", {3'b000, oSalida}, 4'd1);
    chk("data_v0", {3'b000, oValid}, 4'd1);
    iData = 4'b0000;
    step();
    chk("data_s1", {3'b000, oSalida}, 4'd0);
    chk("data_v1", {3'b000, oValid}, 4'd1);
    iData = 4'b1000;
    step();
    chk("data_s2", {3'b000, oSalida}, 4'd1);
    chk("data_v2", {3'b000, oValid}, 4'd1);
    step();
    chk("data_s3", {3'b000, oSalida}, 4'd1);
    chk("data_v3", {3'b000, oValid}, 4'd1);
    chk("data_g3", oGrant, 4'b0000);
    iReq = 4'b0000;
    step();
    chk("data_v4", {3'b000, oValid}, 4'd0);

    // async reset in the middle of a grant to 2
    iReq  = 4'b0100;
    iData = 4'b0100;
    step();
    chk("mid_grant", oGrant, 4'b0100);
    step();
    chk("mid_valid", {3'b000, oValid}, 4'd1);
    chk("mid_sal", {3'b000, oSalida}, 4'd1);
    iRst_n = 1'b0;
    #1;
    chk("mid_rgrant", oGrant, 4'b0000);
    chk("mid_rsel", {2'b00, oSelector}, 4'd0);
    chk("mid_rvalid", {3'b000, oValid}, 4'd0);
    chk("mid_rsal", {3'b000, oSalida}, 4'd0);
    chk("mid_rbusy", {3'b000, oBusy}, 4'd0);
    #1 iRst_n = 1'b1;
    iReq = 4'b1111;
    step();
    chk("post_grant", oGrant, 4'b0001);
    chk("post_valid", {3'b000, oValid}, 4'd0);
    step();
    chk("post_grant2", oGrant, 4'b0001);
    chk("post_valid2", {3'b000, oValid}, 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arbitro_mux_rr.md
# arbitro_mux_rr

Round-robin arbiter and sequencer that shares the 4-input registered multiplexer datapath among four requesters. Each requester raises a request line. The block grants one requester at a time and drives the mux selector to that requester's index. It registers the selected data bit as the output, together with a valid flag. Grants are time-limited so that no single requester can monopolise the shared output.

## Interface
- HOLD_CYCLES, 4: maximum consecutive grant cycles per winner; legal range 1..16.
- iClk  input  1  single clock; all state updates on rising edge.
- iRst_n  input  1  asynchronous, active-low reset.
- iReq  input  4  request lines; bit n = requester n.
- iData  input  4  data bits; bit n is driven by requester n.
- oGrant  output  4  one-hot grant; 4'b0000 when no grant.
- oSelector  output  2  index of the current/last winner (mux select).
- oSalida  output  1  registered selected data bit.
- oValid  output  1  oSalida carries granted data.
- oBusy  output  1  high while in GRANT state.

## Operation

**Reset**
- iRst_n low forces the following immediately, independent of iClk:
  - state = IDLE, rPtr = 0, counter = 0.
  - oGrant = 0, oSelector = 0, oSalida = 0, oValid = 0, oBusy = 0.

**State machine**
- IDLE:
  - oGrant = 0, oBusy = 0.
  - If iReq != 0 at an edge:
    - Pick winner w as the first set bit in search order rPtr, rPtr+1, rPtr+2, rPtr+3 (mod 4).
    - Register oGrant = 1<<w and oSelector = w.
    - Set rPtr = (w+1) mod 4 and counter = HOLD_CYCLES-1.
    - Go to GRANT.
  - If iReq == 0: remain in IDLE; oSelector keeps its last value.
- GRANT:
  - oGrant = one-hot(oSelector), oBusy = 1.
  - At each edge:
    - If iReq[oSelector] == 0 or counter == 0: go to IDLE and clear oGrant.
    - Otherwise decrement counter.
  - Requests from other requesters are ignored during GRANT.
- GRANT → IDLE always inserts at least one cycle with oGrant = 0. The next arbitration occurs at the following edge.
- Counter width is 4 bits, unsigned; it never wraps below 0.

**Data path**
- Every edge: oSalida <= iData[oSelector] and oValid <= (state == GRANT). Both use pre-edge values.
- oSalida still updates when oValid = 0. Consumers must ignore it in that case.

## Timing
- Grant latency: iReq sampled at edge E0 in IDLE → oGrant/oSelector valid after E0 (one cycle).
- Data latency: oSalida/oValid lag oGrant by exactly one cycle. oValid is high for exactly as many cycles as oGrant was high.
- Maximum grant length is HOLD_CYCLES cycles. A held request gives the pattern HOLD_CYCLES cycles granted, then 1 cycle idle.
- A request dropped before edge Ek of GRANT ends the grant at Ek.
- Fairness with all four requesting: worst-case wait = 3 × (HOLD_CYCLES+1) + 1 cycles.
- Simultaneous requests in IDLE resolve by rPtr order only; there are no fixed priorities.
- A single persistent requester is re-granted after each 1-cycle gap. The pointer skips non-requesting bits.
- Reset mid-grant:
  - The grant drops asynchronously, with no partial oValid afterwards.
  - After release, arbitration restarts from rPtr = 0.

## Test plan
- Reset: iRst_n = 0 with iReq = 1111 → all outputs 0. Release with iReq = 0 → oGrant stays 0000 and oBusy stays 0 for 10 cycles.
- Single requester, HOLD_CYCLES = 4, iReq = 0100 held:
  - oGrant = 0100 and oSelector = 2 for 4 cycles, then 0000 for 1 cycle, repeating.
  - oValid is the same pattern shifted by one cycle.
- Rotation: iReq = 1111 from reset → winners 0, 1, 2, 3, 0, each 4 cycles, with a 1-cycle gap between grants. rPtr sequence is 1, 2, 3, 0.
- Early release: requester 1 alone. Drop iReq[1] before the 2nd edge after grant → grant lasts 2 cycles, oValid high for 2 cycles, then IDLE.
- Data: granted to requester 3; toggle iData[3] as 1, 0, 1, 1 while iData[2:0] = 000 → oSalida = 1, 0, 1, 1 one cycle later, with oValid = 1.
- Async reset mid-grant:
  - Pulse iRst_n low between edges during the grant to requester 2 → outputs clear before the next edge.
  - Then with iReq = 1111, the first winner is 0.
